// File: rtl/onehot_encoder_8_to_3_seq.sv
// Serialises the set bits of in_vec into binary indices, lowest first (highest first with ENC_MSB_FIRST_EN).
// First index valid the cycle after acceptance, one index per beat; out_ready stall holds the index and in_ready stays low.
module onehot_encoder_8_to_3_seq #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 zero_seen
);

   localparam int W = $clog2(N);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [0:0]   state;
   logic [N-1:0] pend;
   logic [W-1:0] sel;
   logic         single;

   // Loop order makes the last match win, giving the priority end of the scan.
   always_comb begin
      sel = '0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < N; i++) begin
         if (pend[i]) sel = W'(i);
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
         if (pend[i]) sel = W'(i);
      end
`endif
   end

   assign single    = (pend != '0) && ((pend & (pend - ONE)) == '0);
   assign out_valid = (state == EMIT);
   assign out_idx   = (state == EMIT) ? sel : '0;
   assign out_last  = (state == EMIT) && single;

   // in_ready is registered so it stays low through reset and rises one cycle after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         zero_seen <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         zero_seen <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (in_vec != '0) begin
                     pend     <= in_vec;
                     state    <= EMIT;
                     in_ready <= 1'b0;
                  end else begin
                     zero_seen <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pend <= pend & ~(ONE << sel);
                  if (single) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               pend     <= '0;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
